// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 16-bit six-control-bit ALU.
// Defining ALU_SEQ_MUL_EN builds the shift-add MUL loop; otherwise opcode 8 is illegal.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_o,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_zr,
    output logic        res_ng,
    output logic        res_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        MUL_ACC = 3'd2,
        MUL_DBL = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [5:0] CTRL_ADD = 6'b000010;

    state_e      state_q;
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] resData_q;
    logic        resZr_q;
    logic        resNg_q;
    logic        resErr_q;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
    logic [15:0] acc_q;
    logic [15:0] mcand_q;
    logic [15:0] mplier_q;
    logic [3:0]  cnt_q;
`endif

    logic        opLegal;
    logic [15:0] resData_d;
    logic [5:0]  ctrl;

    function automatic logic [5:0] ctrlWord(input logic [3:0] op);
        case (op)
            4'd0:    ctrlWord = 6'b000010;
            4'd1:    ctrlWord = 6'b010011;
            4'd2:    ctrlWord = 6'b000000;
            4'd3:    ctrlWord = 6'b010101;
            4'd4:    ctrlWord = 6'b001111;
            4'd5:    ctrlWord = 6'b011111;
            4'd6:    ctrlWord = 6'b001110;
            4'd7:    ctrlWord = 6'b001100;
            default: ctrlWord = 6'b000000;
        endcase
    endfunction

    // MUL never reaches EXEC, so only opcodes 0-7 are legal single-pass ops.
    assign opLegal   = ~op_q[3];
    assign resData_d = opLegal ? alu_o : 16'h0000;

    always_comb begin
        ctrl  = 6'b000000;
        alu_x = 16'h0000;
        alu_y = 16'h0000;
        case (state_q)
            EXEC: begin
                alu_x = a_q;
                alu_y = b_q;
                ctrl  = ctrlWord(op_q);
            end
`ifdef ALU_SEQ_MUL_EN
            MUL_ACC: begin
                alu_x = acc_q;
                alu_y = mcand_q;
                ctrl  = CTRL_ADD;
            end
            MUL_DBL: begin
                alu_x = mcand_q;
                alu_y = mcand_q;
                ctrl  = CTRL_ADD;
            end
`endif
            default: ;
        endcase
    end

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;
    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign res_data  = resData_q;
    assign res_zr    = resZr_q;
    assign res_ng    = resNg_q;
    assign res_err   = resErr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 4'd0;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            resData_q <= 16'h0000;
            resZr_q   <= 1'b0;
            resNg_q   <= 1'b0;
            resErr_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q     <= 16'h0000;
            mcand_q   <= 16'h0000;
            mplier_q  <= 16'h0000;
            cnt_q     <= 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        state_q <= EXEC;
`ifdef ALU_SEQ_MUL_EN
                        if (cmd_op == OP_MUL) begin
                            acc_q    <= 16'h0000;
                            mcand_q  <= cmd_a;
                            mplier_q <= cmd_b;
                            cnt_q    <= 4'd0;
                            state_q  <= MUL_ACC;
                        end
`endif
                    end
                end
                EXEC: begin
                    resData_q <= resData_d;
                    resZr_q   <= (resData_d == 16'h0000);
                    resNg_q   <= resData_d[15];
                    resErr_q  <= ~opLegal;
                    state_q   <= DONE;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL_ACC: begin
                    if (mplier_q[0]) begin
                        acc_q <= alu_o;
                    end
                    state_q <= MUL_DBL;
                end
                MUL_DBL: begin
                    mcand_q  <= alu_o;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        resData_q <= acc_q;
                        resZr_q   <= (acc_q == 16'h0000);
                        resNg_q   <= acc_q[15];
                        resErr_q  <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        state_q <= MUL_ACC;
                    end
                end
`endif
                DONE: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the 16-bit six-control-bit ALU (zx, nx, zy, ny, f, no). It accepts opcode commands over a valid/ready handshake and drives the ALU's control bits and operands. Single-pass ops complete in one ALU cycle; MUL runs as a multi-cycle shift-add loop using only the ALU's ADD function. The result is returned over a second valid/ready handshake. It sits between an instruction decoder and the combinational ALU instance.

## Interface
Parameters:
- none; width fixed at 16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready at rising edge
- cmd_op  in  4  opcode
- cmd_a, cmd_b  in  16 each  operands
- alu_x, alu_y  out  16 each  ALU operand drive
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control drive
- alu_o  in  16  ALU result (combinational, sampled same cycle)
- res_valid  out  1  result present
- res_ready  in  1  result consumed when valid&ready at rising edge
- res_data  out  16  result
- res_zr  out  1  res_data==0
- res_ng  out  1  res_data[15]
- res_err  out  1  illegal or disabled opcode

## Operation
- Opcodes and their control words, given as zx nx zy ny f no:
  - 0 ADD x+y: 000010
  - 1 SUB x−y: 010011
  - 2 AND: 000000
  - 3 OR: 010101
  - 4 NEGX: 001111
  - 5 INCX: 011111
  - 6 DECX: 001110
  - 7 PASSX: 001100
  - 8 MUL; every other opcode is illegal.
- States: IDLE, EXEC, MUL_ACC, MUL_DBL, DONE.
- IDLE:
  - cmd_ready=1; ALU controls and operands driven 0.
  - On accept, latch op, a, b.
  - Opcodes 0–7 and illegal opcodes → EXEC; MUL → MUL_ACC with acc=0, mcand=a, mplier=b, cnt=0.
- EXEC:
  - Drive alu_x=a, alu_y=b and the op's control word.
  - At the edge, res_data←alu_o, res_err←0, → DONE.
  - Illegal opcode: controls driven 0, res_data←0, res_err←1.
- MUL_ACC: drive x=acc, y=mcand, ADD. If mplier[0], acc←alu_o; else acc holds. → MUL_DBL.
- MUL_DBL:
  - Drive x=mcand, y=mcand, ADD; mcand←alu_o; mplier←mplier>>1; cnt←cnt+1.
  - If cnt==15 → DONE with res_data←acc; else → MUL_ACC.
- MUL result is the low 16 bits of a×b; overflow is silently discarded and both operands are treated as unsigned.
- DONE:
  - res_valid=1; res_data, res_zr, res_ng, res_err are stable.
  - On res_ready → IDLE.
- cmd_ready=0 in every state except IDLE. A command cannot be accepted in the same cycle a result is consumed.
- Reset values: state IDLE, every register 0, res_valid=0, res_data=0, res_zr=0, res_ng=0, res_err=0, all ALU outputs 0. cmd_ready reads 1 while in reset.
- Reset mid-operation aborts immediately; no result is produced.

## Timing
- Accept at edge k:
  - Single-pass op: EXEC during cycle k..k+1; res_valid high from edge k+1.
  - MUL: 32 ALU cycles; res_valid high from edge k+32.
- Minimum command-to-command spacing: 3 edges for single-pass ops (accept, capture, consume).
- res_zr and res_ng are derived from the registered res_data, never taken from ALU flags.
- alu_x, alu_y and controls are registered-state decodes and change only after a rising edge. The alu_o path is combinational within one cycle.

## Configuration
- ALU_SEQ_MUL_EN:
  - Defined: MUL is supported as specified.
  - Undefined: MUL_ACC, MUL_DBL and the acc/mcand/mplier/cnt registers are not built. Opcode 8 is treated as illegal (EXEC, res_data=0, res_err=1, latency 1).

## Test plan
- Reset then ADD a=3, b=4 → res_valid at accept+1, res_data=7, zr=0, ng=0, err=0; alu controls 000010 during EXEC.
- SUB a=5, b=7 → res_data=0xFFFE, ng=1. INCX a=0xFFFF → res_data=0, zr=1.
- MUL a=300, b=200 → res_valid exactly 32 cycles after accept, res_data=0xEA60, ng=1. MUL a=0x0100, b=0x0100 → res_data=0, zr=1.
- Hold res_ready low 5 cycles after res_valid → res_data and flags stable, cmd_ready=0, and a cmd_valid pulse is not accepted.
- Opcode 0xF → res_data=0, res_err=1. Without ALU_SEQ_MUL_EN, opcode 8 → same response at latency 1.
- Assert rst_n low at cycle 10 of a MUL → all outputs return to reset values asynchronously. After release, ADD 1+1 → 2 with no stale result.
